// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit arbiter.
package tx_pkg;

  localparam int BYTE_W          = 8;
  localparam int GAP_DEFAULT     = 2;
  localparam int TIMEOUT_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after index 'last', with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial byte transmitter between NREQ requesters.
// state   | meaning
// IDLE    | waiting for any req; grants and latches the winner's byte on exit
// LOAD    | load held high until hempTea or timeout
// RELEASE | one cycle: load low, transmitter reset, ack or err pulse
// GAP     | GAP idle cycles before the next grant
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GAP     = GAP_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BYTE_W-1:0] data,
  output logic [NREQ-1:0]        ack,
  output logic                   err,
  output logic                   busy,
  output logic                   load,
  output logic [BYTE_W-1:0]      txByte,
  output logic                   txRst,
  input  logic                   hempTea
);

  localparam int IW     = $clog2(NREQ);
  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int GW_RAW = $clog2(GAP + 1);
  localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e              state_q, state_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]       last_q, last_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                load_q, load_d;
  logic                tx_rst_q, tx_rst_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                err_q, err_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;

  logic [IW-1:0]       winner;
  logic                any;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    tx_byte_d = tx_byte_q;
    load_d    = 1'b0;
    tx_rst_d  = 1'b0;
    ack_d     = '0;
    err_d     = 1'b0;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (any) begin
          gnt_d     = winner;
          last_d    = winner;
          tx_byte_d = data[int'(winner)*BYTE_W +: BYTE_W];
          load_d    = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // hempTea is tested first so a completion on the timeout cycle still counts
        if (hempTea) begin
          tx_rst_d     = 1'b1;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_RELEASE;
        end else if (tcnt_q == T_LAST) begin
          tx_rst_d = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_RELEASE;
        end else begin
          load_d = 1'b1;
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RELEASE: begin
        gcnt_d  = '0;
        state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gcnt_q == G_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= IW'(NREQ - 1);
      tx_byte_q <= '0;
      load_q    <= 1'b0;
      tx_rst_q  <= 1'b1;
      ack_q     <= '0;
      err_q     <= 1'b0;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      tx_byte_q <= tx_byte_d;
      load_q    <= load_d;
      tx_rst_q  <= tx_rst_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);
  assign load   = load_q;
  assign txByte = tx_byte_q;
  assign txRst  = tx_rst_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter with a frame-level round-robin reference model.
module tb_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic        load;
  logic [7:0]  txByte;
  logic        txRst;
  logic        hempTea = 1'b0;

  int checks  = 0;
  int errors  = 0;
  int m_last  = NREQ - 1;
  int mon_bad = 0;

  always #5 clk = ~clk;

  tx_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .load    (load),
    .txByte  (txByte),
    .txRst   (txRst),
    .hempTea (hempTea)
  );

  // ack must be at most one-hot and never coincide with err
  always @(negedge clk) begin
    if (rst && ((((ack & (ack - 4'd1)) != 4'd0)) || (ack != 4'd0 && err))) mon_bad++;
  end

  function automatic int model_pick(input logic [3:0] r, input int last);
    int idx;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int exp_lcyc(input int hd);
    return (hd >= 0 && hd < TIMEOUT) ? hd + 1 : TIMEOUT;
  endfunction

  task automatic apply_reset;
    rst = 1'b0; req = '0; hempTea = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_last = NREQ - 1;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < 100) begin @(posedge clk); #1; c++; end
  endtask

  // Drives one frame with a shiftOut stand-in raising hempTea in LOAD cycle hdelay (-1 = never).
  task automatic do_frame(input int hdelay, input logic [3:0] mid_req, input logic [31:0] mid_data,
                          output int lat, output logic [7:0] obyte, output logic stable,
                          output int lcyc, output logic [3:0] rack, output logic rerr,
                          output logic rtxrst, output logic [3:0] nack, output logic nerr);
    lat = 0;
    while (!load && lat < 200) begin @(posedge clk); #1; lat++; end
    obyte = txByte; stable = 1'b1;
    req = mid_req; data = mid_data;
    lcyc = 0;
    hempTea = (hdelay == 0);
    while (load && lcyc < 200) begin
      @(posedge clk); #1; lcyc++;
      if (load) begin
        if (txByte !== obyte) stable = 1'b0;
        hempTea = (hdelay == lcyc);
      end
    end
    hempTea = 1'b0;
    rack = ack; rerr = err; rtxrst = txRst;
    @(posedge clk); #1;
    nack = ack; nerr = err;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
    checks++; if (txByte !== 8'h00) begin errors++; $display("FAIL reset_txbyte: got %h expected 00", txByte); end
    checks++; if (txRst !== 1'b1) begin errors++; $display("FAIL reset_txrst: got %b expected 1", txRst); end
    checks++; if (ack !== 4'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ack=%b err=%b busy=%b expected 0", ack, err, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (txRst !== 1'b0) begin errors++; $display("FAIL release_txrst: got %b expected 0", txRst); end
  endtask

  task automatic test_single;
    int lat, lcyc, hd, w, c;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na;
    apply_reset;
    data = 32'h0000_00A5; req = 4'b0001;
    hd = int'($urandom_range(0, 10));
    w = model_pick(req, m_last); m_last = w;
    do_frame(hd, req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
    req = '0;
    checks++; if (lat != 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
    checks++; if (ob !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h expected a5", ob); end
    checks++; if (lcyc != exp_lcyc(hd)) begin errors++; $display("FAIL single_loadlen: got %0d expected %0d", lcyc, exp_lcyc(hd)); end
    checks++; if (ra !== (4'b0001 << w) || re !== 1'b0) begin errors++; $display("FAIL single_ack: got %b err=%b expected %b", ra, re, 4'b0001 << w); end
    checks++; if (rt !== 1'b1) begin errors++; $display("FAIL single_txrst: got %b expected 1", rt); end
    checks++; if (na !== 4'b0) begin errors++; $display("FAIL single_ack_width: got %b expected 0000", na); end
    wait_idle(c);
    checks++; if (c != GAP) begin errors++; $display("FAIL single_busy_gap: got %0d expected %0d", c, GAP); end
  endtask

  task automatic test_rotation;
    int lat, lcyc, hd, w, c;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na;
    apply_reset;
    data = 32'h1312_1110; req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      hd = int'($urandom_range(0, 12));
      w = model_pick(req, m_last); m_last = w;
      do_frame(hd, req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
      checks++; if (ob !== 8'(8'h10 + w)) begin errors++; $display("FAIL rot_byte%0d: got %h expected %h", f, ob, 8'(8'h10 + w)); end
      checks++; if (ra !== (4'b0001 << w)) begin errors++; $display("FAIL rot_ack%0d: got %b expected %b", f, ra, 4'b0001 << w); end
      checks++; if (lat != ((f == 0) ? 1 : GAP + 1)) begin errors++; $display("FAIL rot_lat%0d: got %0d expected %0d", f, lat, (f == 0) ? 1 : GAP + 1); end
    end
    req = '0;
    wait_idle(c);
  endtask

  task automatic test_continuous;
    int lat, lcyc, hd, w, c, prev_l;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na;
    apply_reset;
    data = $urandom; req = 4'b0100; prev_l = 0;
    for (int f = 0; f < 3; f++) begin
      hd = int'($urandom_range(0, 8));
      w = model_pick(req, m_last); m_last = w;
      do_frame(hd, req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
      checks++; if (ra !== 4'b0100) begin errors++; $display("FAIL cont_ack%0d: got %b expected 0100", f, ra); end
      if (f > 0) begin
        // period between load rises = previous LOAD length + release + lat
        checks++; if (prev_l + 1 + lat != 1 + prev_l + 1 + GAP) begin
          errors++; $display("FAIL cont_period%0d: got %0d expected %0d", f, prev_l + 1 + lat, prev_l + 2 + GAP); end
      end
      prev_l = lcyc;
    end
    req = '0;
    wait_idle(c);
  endtask

  task automatic test_timeout;
    int lat, lcyc, w, c;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na;
    apply_reset;
    data = $urandom; req = 4'b0001;
    w = model_pick(req, m_last); m_last = w;
    do_frame(-1, req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
    checks++; if (lcyc != TIMEOUT) begin errors++; $display("FAIL to_loadlen: got %0d expected %0d", lcyc, TIMEOUT); end
    checks++; if (re !== 1'b1 || ra !== 4'b0) begin errors++; $display("FAIL to_err: got err=%b ack=%b expected err=1 ack=0000", re, ra); end
    checks++; if (ne !== 1'b0) begin errors++; $display("FAIL to_err_width: got %b expected 0", ne); end
    req = 4'b0011;
    w = model_pick(req, m_last); m_last = w;
    do_frame(int'($urandom_range(0, 10)), req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
    checks++; if (ra !== (4'b0001 << w) || re !== 1'b0) begin errors++; $display("FAIL to_next_ack: got %b err=%b expected %b", ra, re, 4'b0001 << w); end
    checks++; if (ob !== data[8*w +: 8]) begin errors++; $display("FAIL to_next_byte: got %h expected %h", ob, data[8*w +: 8]); end
    req = 4'b0001;
    w = model_pick(req, m_last); m_last = w;
    do_frame(TIMEOUT - 1, req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
    checks++; if (lcyc != TIMEOUT || ra !== 4'b0001 || re !== 1'b0) begin
      errors++; $display("FAIL to_edge_win: got len=%0d ack=%b err=%b expected len=%0d ack=0001 err=0", lcyc, ra, re, TIMEOUT); end
    req = '0;
    wait_idle(c);
  endtask

  task automatic test_async_reset;
    int lat, lcyc, w, c;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na;
    logic saw_ack;
    apply_reset;
    data = 32'h4433_2211; req = 4'b0001;
    @(posedge clk); #1;
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL ar_load_up: got %b expected 1", load); end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (load !== 1'b0 || txRst !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ar_immediate: got load=%b txRst=%b busy=%b expected 0 1 0", load, txRst, busy); end
    saw_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ack !== 4'b0) saw_ack = 1'b1; end
    checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL ar_no_ack: got %b expected 0", saw_ack); end
    rst = 1'b1; m_last = NREQ - 1;
    req = 4'b1001;
    w = model_pick(req, m_last); m_last = w;
    do_frame(int'($urandom_range(0, 6)), req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
    checks++; if (ra !== (4'b0001 << w) || ob !== data[8*w +: 8]) begin
      errors++; $display("FAIL ar_first_winner: got ack=%b byte=%h expected %b %h", ra, ob, 4'b0001 << w, data[8*w +: 8]); end
    req = '0;
    wait_idle(c);
  endtask

  task automatic test_drop;
    int lat, lcyc, c;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na;
    apply_reset;
    data = 32'h0000_005A; req = 4'b0001;
    m_last = model_pick(req, m_last);
    do_frame(int'($urandom_range(2, 10)), 4'b0000, 32'h0000_00FF, lat, ob, st, lcyc, ra, re, rt, na, ne);
    checks++; if (ob !== 8'h5A || st !== 1'b1) begin errors++; $display("FAIL drop_byte: got %h stable=%b expected 5a stable=1", ob, st); end
    checks++; if (ra !== 4'b0001) begin errors++; $display("FAIL drop_ack: got %b expected 0001", ra); end
    wait_idle(c);
  endtask

  task automatic test_random;
    int lat, lcyc, hd, w, c;
    logic [7:0] ob; logic st, re, rt, ne; logic [3:0] ra, na, exp_a;
    logic exp_e;
    apply_reset;
    for (int f = 0; f < 12; f++) begin
      req = 4'($urandom_range(1, 15));
      data = $urandom;
      hd = int'($urandom_range(0, TIMEOUT + 3));
      w = model_pick(req, m_last); m_last = w;
      exp_e = !(hd < TIMEOUT);
      exp_a = exp_e ? 4'b0 : (4'b0001 << w);
      do_frame(hd, req, data, lat, ob, st, lcyc, ra, re, rt, na, ne);
      req = '0;
      checks++; if (ob !== data[8*w +: 8] || lat != 1) begin
        errors++; $display("FAIL rnd_grant%0d: got byte=%h lat=%0d expected %h 1", f, ob, lat, data[8*w +: 8]); end
      checks++; if (ra !== exp_a || re !== exp_e || lcyc != exp_lcyc(hd)) begin
        errors++; $display("FAIL rnd_result%0d: got ack=%b err=%b len=%0d expected %b %b %0d", f, ra, re, lcyc, exp_a, exp_e, exp_lcyc(hd)); end
      wait_idle(c);
    end
  endtask

  task automatic test_monitor;
    checks++; if (mon_bad != 0) begin errors++; $display("FAIL ack_onehot_excl: got %0d violations expected 0", mon_bad); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_continuous;
    test_timeout;
    test_async_reset;
    test_drop;
    test_random;
    test_monitor;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin scheduler that shares the single serial byte transmitter (shiftOut) between NREQ requesters.
- Latches the winning requester's byte and drives the transmitter's load/byteIn handshake.
- Waits for hempTea, then releases load and pulses the transmitter reset, so the microprocessor-side handshake is automated.
- Sits between requesting blocks and shiftOut; one frame is in flight at a time.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- GAP, 2: idle cycles inserted after each frame before the next grant; 0 allowed.
- TIMEOUT, 32: max cycles in LOAD waiting for hempTea before abort; must be > 11.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester transmit request; level, held until ack.
- data  input  NREQ*8  byte of requester i on data[8i+7:8i].
- ack  output  NREQ  one-cycle pulse to the requester whose frame completed.
- err  output  1  one-cycle pulse on timeout abort.
- busy  output  1  high in any state other than IDLE.
- load  output  1  to shiftOut load.
- txByte  output  8  to shiftOut byteIn; registered.
- txRst  output  1  to shiftOut rst; active-high, one cycle per frame.
- hempTea  input  1  from shiftOut: frame sent.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; load=0, txByte=0, txRst=1 (holds the transmitter in reset), ack=0, err=0, busy=0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Cycle counters = 0.
- First clk edge after reset release: txRst=0.
- Reset asserted mid-frame: load drops immediately, no ack, and the frame is lost.
- FSM states: IDLE, LOAD, RELEASE, GAP.
- IDLE:
  - If any req bit is set, grant the first set bit searching from (last+1) mod NREQ upward with wrap.
  - On the same edge: gnt<=winner, last<=winner, txByte<=data[winner], load<=1, state<=LOAD.
  - Latency from req to load is 1 cycle.
- LOAD:
  - Holds load=1 and txByte stable; the timeout counter increments every cycle.
  - If hempTea=1: state<=RELEASE.
  - Else if counter reaches TIMEOUT-1: state<=RELEASE with the abort flag set.
  - If hempTea arrives on the timeout cycle, hempTea wins and the frame counts as success.
- RELEASE (exactly 1 cycle):
  - load=0, txRst=1.
  - ack[gnt]=1 on success, or err=1 on abort (ack stays 0).
  - Next state is GAP if GAP>0, else IDLE.
- GAP: hold for GAP cycles with load=0 and txRst=0, then go to IDLE.
- Throughput per frame: 1 (IDLE) + LOAD duration + 1 + GAP cycles. No grant is made in RELEASE or GAP.
- req rules:
  - A req dropped while granted is ignored; the frame completes and ack still pulses.
  - A req held after ack is a new request and competes in the next IDLE.
  - Data changes after grant have no effect, because txByte is latched.
- All NREQ requesting continuously gives strict rotation 0,1,..,NREQ-1,0.
- A single continuous requester is re-granted every frame.
- Outputs are registered; ack is at most one-hot; ack and err are mutually exclusive.
- Counter widths: clog2(TIMEOUT+1) and clog2(GAP+1), with a minimum of 1 bit.

Decomposition:
- Shared package tx_pkg:
  - state enum {IDLE, LOAD, RELEASE, GAP}.
  - BYTE_W=8.
  - Default GAP and TIMEOUT constants.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NREQ], last index.
  - Outputs: winner index, any.

Test Plan:
- Reset then req=4'b0001 with data0=8'hA5:
  - load rises 1 cycle later with txByte=A5.
  - Once a shiftOut model raises hempTea, RELEASE gives ack=0001 for exactly 1 cycle with txRst=1.
  - busy falls after GAP=2 cycles.
- req=4'b1111 held, data i = 8'h10+i: txByte sequence 10,11,12,13,10, with ack one-hot in the same order.
- req=4'b0100 held alone: re-granted every frame; the gap between successive load rises equals the frame time + 1 + GAP.
- hempTea tied 0: err pulses after TIMEOUT=32 cycles in LOAD, ack stays 0, load drops, and the next requester is served normally.
- rst driven low asynchronously mid-LOAD:
  - load=0 and txRst=1 immediately, without waiting for a clock edge.
  - No ack is issued.
  - After release, requester 0 wins first.
- req0 dropped while granted, with data0 changed to 8'hFF mid-frame: txByte stays at the original value, and ack[0] still pulses.
